serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sub_pkg.sv | 19 +
 rtl/full_subtractor.sv | 46 ++++
 rtl/serial_subtractor.sv | 105 ++++++++++
 tb/tb_serial_subtractor.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the bit-serial subtractor
package sub_pkg;

    // Default operand/result width; legal widths are 2..32.
    localparam int SUB_WIDTH_DEFAULT = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor built from two half subtractors
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    // Difference is the XOR; a borrow is needed only for 0 - 1.
    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First stage subtracts the operand bits.
    half_subtractor u_hs_xy (
        .a    (x),
        .b    (y),
        .d    (d1),
        .bout (b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_subtractor u_hs_bin (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (b2)
    );

    // The two stages can never both borrow, so OR merges them.
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor, one bit per clock
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    sub_state_t        state;
    logic [WIDTH-1:0]  x_sr;
    logic [WIDTH-1:0]  y_sr;
    logic [WIDTH-1:0]  diff_r;
    logic              borrow_r;
    logic              bin_r;
    logic [CW-1:0]     cnt;
    logic              busy_r;
    logic              done_r;

    logic              fs_d;
    logic              fs_bout;

    // The single bit-slice; it always works on the current LSBs of the operands.
    full_subtractor u_fs (
        .x    (x_sr[0]),
        .y    (y_sr[0]),
        .bin  (bin_r),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Sequencer, operand shifters and result register; all outputs are registered.
    // The running borrow (bin_r) is separate from the visible borrow output so the
    // last completed result stays readable while the next operation is shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_sr     <= '0;
            y_sr     <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            bin_r    <= 1'b0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x_sr   <= x;
                        y_sr   <= y;
                        bin_r  <= 1'b0;
                        cnt    <= '0;
                        state  <= SHIFT;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end

                SHIFT: begin
                    // start is deliberately ignored here.
                    x_sr   <= x_sr >> 1;
                    y_sr   <= y_sr >> 1;
                    diff_r <= {fs_d, diff_r[WIDTH-1:1]};
                    bin_r  <= fs_bout;
                    if (cnt == CNT_LAST) begin
                        borrow_r <= fs_bout;
                        state    <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    int errors;
    int checks;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for done; reports result and timing.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] d, output logic bo,
                         output int lat, output int bcnt);
        start = 1'b1;
        x     = a;
        y     = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        d  = diff;
        bo = borrow;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        x     = 8'h00;
        y     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [7:0] d;
        logic       bo;
        int         lat;
        int         bcnt;
        do_op(8'h5A, 8'h3C, d, bo, lat, bcnt);
        checks++; if (d !== 8'h1E) begin errors++; $display("FAIL basic_diff got=%h exp=1e", d); end
        checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_borrow got=%b exp=0", bo); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bcnt); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (diff !== 8'h1E) begin errors++; $display("FAIL basic_hold_idle got=%h exp=1e", diff); end
    endtask

    task automatic test_vectors;
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic [7:0] vd [6];
        logic       vbo [6];
        logic [7:0] d;
        logic       bo;
        int         lat;
        int         bcnt;
        va[0] = 8'h3C; vb[0] = 8'h5A; vd[0] = 8'hE2; vbo[0] = 1'b1;
        va[1] = 8'h00; vb[1] = 8'h01; vd[1] = 8'hFF; vbo[1] = 1'b1;
        va[2] = 8'hFF; vb[2] = 8'hFF; vd[2] = 8'h00; vbo[2] = 1'b0;
        va[3] = 8'h01; vb[3] = 8'h00; vd[3] = 8'h01; vbo[3] = 1'b0;
        va[4] = 8'h80; vb[4] = 8'h7F; vd[4] = 8'h01; vbo[4] = 1'b0;
        va[5] = 8'h00; vb[5] = 8'h80; vd[5] = 8'h80; vbo[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], d, bo, lat, bcnt);
            checks++; if (d !== vd[i]) begin errors++; $display("FAIL vec%0d_diff got=%h exp=%h", i, d, vd[i]); end
            checks++; if (bo !== vbo[i]) begin errors++; $display("FAIL vec%0d_borrow got=%b exp=%b", i, bo, vbo[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold_during_shift;
        logic [7:0] d;
        logic       bo;
        int         lat;
        int         bcnt;
        do_op(8'h00, 8'h01, d, bo, lat, bcnt);
        @(posedge clk); #1;
        start = 1'b1;
        x     = 8'h05;
        y     = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got=%b exp=1", busy); end
        checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL hold_borrow got=%b exp=1", borrow); end
        checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL hold_diff got=%h exp=ff", diff); end
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (diff !== 8'h04 || borrow !== 1'b0) begin
            errors++; $display("FAIL hold_result got=%h/%b exp=04/0", diff, borrow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_operand_change;
        int lat;
        start = 1'b1;
        x     = 8'h12;
        y     = 8'h34;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            x = 8'($urandom);
            y = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (diff !== 8'hDE || borrow !== 1'b1) begin
            errors++; $display("FAIL opchange_result got=%h/%b exp=de/1", diff, borrow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] pa [5];
        logic [7:0] pb [5];
        logic [8:0] expv;
        int         edges;
        for (int i = 0; i < 5; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
        pa[0] = 8'h10; pb[0] = 8'h20;
        start = 1'b1;
        x     = pa[0];
        y     = pb[0];
        for (int i = 0; i < 5; i++) begin
            edges = 0;
            do begin
                @(posedge clk); #1;
                edges++;
            end while (!done && edges < 40);
            expv = {1'b0, pa[i]} - {1'b0, pb[i]};
            checks++; if (edges !== 9) begin errors++; $display("FAIL b2b%0d_period got=%0d exp=9", i, edges); end
            checks++; if (diff !== expv[7:0] || borrow !== expv[8]) begin
                errors++; $display("FAIL b2b%0d_result got=%h/%b exp=%h/%b", i, diff, borrow, expv[7:0], expv[8]);
            end
            if (i < 4) begin
                x = pa[i+1];
                y = pb[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored;
        int lat;
        start = 1'b1;
        x     = 8'h80;
        y     = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        start = 1'b1;
        x     = 8'h00;
        y     = 8'hFF;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
        checks++; if (diff !== 8'h7F || borrow !== 1'b0) begin
            errors++; $display("FAIL ignore_result got=%h/%b exp=7f/0", diff, borrow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic       bo;
        int         lat;
        int         bcnt;
        int         seen_done;
        start = 1'b1;
        x     = 8'hA5;
        y     = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got=%b/%b/%h/%b exp=0/0/00/0", busy, done, diff, borrow);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", seen_done); end
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        do_op(8'hA5, 8'h5A, d, bo, lat, bcnt);
        checks++; if (lat !== 8) begin errors++; $display("FAIL postreset_latency got=%0d exp=8", lat); end
        checks++; if (d !== 8'h4B || bo !== 1'b0) begin
            errors++; $display("FAIL postreset_result got=%h/%b exp=4b/0", d, bo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic [8:0] expv;
        int         lat;
        int         bcnt;
        for (int i = 0; i < 2000; i++) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            expv = {1'b0, a} - {1'b0, b};
            do_op(a, b, d, bo, lat, bcnt);
            checks++; if (d !== expv[7:0]) begin
                errors++; $display("FAIL rand%0d_diff x=%h y=%h got=%h exp=%h", i, a, b, d, expv[7:0]);
            end
            checks++; if (bo !== (a < b)) begin
                errors++; $display("FAIL rand%0d_borrow x=%h y=%h got=%b exp=%b", i, a, b, bo, (a < b));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        x      = 8'h00;
        y      = 8'h00;
        test_reset;
        test_basic;
        test_vectors;
        test_hold_during_shift;
        test_operand_change;
        test_back_to_back;
        test_start_ignored;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
